// File: rtl/demux_pkg.sv
// Shared types and helpers for the serial scan collector.
// Holds the FSM state type and the select width function.
package demux_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  // Width of a select index for n positions, never narrower than 1 bit.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/demux_n_collect_sel_decoder.sv
// Binary scan index to one-hot bit enable.
// Indices at or above N decode to all zeros.
module sel_decoder
  import demux_pkg::*;
#(
  parameter int N = 16,
  localparam int SELW = sel_width(N)
) (
  input  logic [SELW-1:0] sel,
  output logic [N-1:0]    en
);

  // One-hot decode; out-of-range indices match no bit.
  always_comb begin
    en = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) en[i] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_n_collect.sv
// Receive end of a mux-driven serial scan.
// Steers each accepted bit into Q[sel_out] and hands the word off.
module demux_n_collect
  import demux_pkg::*;
#(
  parameter int N = 16,
  localparam int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            d_in,
  input  logic            d_valid,
  output logic [SELW-1:0] sel_out,
  output logic            busy,
  output logic [N-1:0]    Q,
  output logic            q_valid,
  input  logic            q_ready
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  state_t      state;
  logic        cap;
  logic        clr;
  logic [N-1:0] en;

  // A bit is taken only while collecting and the source marks it valid.
  assign cap = (state == COLLECT) && d_valid;

  // A new word begins from IDLE, or from DONE once the old word is taken.
  assign clr = start && ((state == IDLE) ||
                         ((state == DONE) && q_ready));

  sel_decoder #(.N(N)) u_dec (
    .sel (sel_out),
    .en  (en)
  );

  // Control FSM: state, scan index and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel_out <= '0;
      busy    <= 1'b0;
      q_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= COLLECT;
            sel_out <= '0;
            busy    <= 1'b1;
          end
        end
        COLLECT: begin
          if (d_valid) begin
            if (sel_out == LAST) begin
              state   <= DONE;
              sel_out <= '0;
              busy    <= 1'b0;
              q_valid <= 1'b1;
            end else begin
              sel_out <= sel_out + 1'b1;
            end
          end
        end
        DONE: begin
          if (q_ready) begin
            q_valid <= 1'b0;
            if (start) begin
              state   <= COLLECT;
              sel_out <= '0;
              busy    <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          sel_out <= '0;
          busy    <= 1'b0;
          q_valid <= 1'b0;
        end
      endcase
    end
  end

  // Word register: cleared on a new start, else one bit per capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q <= '0;
    end else if (clr) begin
      Q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cap && en[i]) Q[i] <= d_in;
      end
    end
  end

endmodule

// File: tb/tb_demux_n_collect.sv
// Directed bench for demux_n_collect at N=16 and N=5.
// Expected words go through a scoreboard queue.
module tb_demux_n_collect;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        a_st = 0, a_din = 0, a_dv = 0, a_rdy = 0;
  logic [3:0]  a_sel;
  logic        a_busy, a_qv;
  logic [15:0] a_q;

  logic        b_st = 0, b_din = 0, b_dv = 0, b_rdy = 0;
  logic [2:0]  b_sel;
  logic        b_busy, b_qv;
  logic [4:0]  b_q;

  logic [15:0] sbq[$];
  logic [4:0]  sb5[$];
  logic [15:0] exp16;
  logic [4:0]  exp5;
  logic [4:0]  w5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_n_collect #(.N(16)) dut_a (
    .clk(clk), .reset(reset), .start(a_st),
    .d_in(a_din), .d_valid(a_dv), .sel_out(a_sel),
    .busy(a_busy), .Q(a_q), .q_valid(a_qv),
    .q_ready(a_rdy)
  );

  demux_n_collect #(.N(5)) dut_b (
    .clk(clk), .reset(reset), .start(b_st),
    .d_in(b_din), .d_valid(b_dv), .sel_out(b_sel),
    .busy(b_busy), .Q(b_q), .q_valid(b_qv),
    .q_ready(b_rdy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Called on the negedge after the start edge; ends in DONE.
  task automatic a_feed(input logic [15:0] w,
                        input int st_at,
                        input int st_len);
    sbq.push_back(w);
    for (int i = 0; i < 16; i++) begin
      chk("a_sel", 32'(a_sel), i);
      chk("a_busy", 32'(a_busy), 1);
      chk("a_qv_low", 32'(a_qv), 0);
      a_dv = 1'b1;
      a_din = w[i];
      a_st = (i == 8);
      @(negedge clk);
      if (i == st_at) begin
        a_dv = 1'b0;
        a_st = 1'b0;
        for (int k = 0; k < st_len; k++) begin
          chk("a_stall_sel", 32'(a_sel), i + 1);
          a_din = ~a_din;
          @(negedge clk);
        end
      end
    end
    a_dv = 1'b0;
    a_st = 1'b0;
    chk("a_qv_rise", 32'(a_qv), 1);
    chk("a_busy_done", 32'(a_busy), 0);
    chk("a_sel_wrap", 32'(a_sel), 0);
    chk("a_sb_nonempty", 32'(sbq.size() != 0), 1);
    if (sbq.size() != 0) begin
      exp16 = sbq.pop_front();
      chk("a_word", 32'(a_q), 32'(exp16));
    end
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_sel", 32'(a_sel), 0);
    chk("rst_q", 32'(a_q), 0);
    chk("rst_qv", 32'(a_qv), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_b_sel", 32'(b_sel), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(a_busy), 0);
    chk("idle_qv", 32'(a_qv), 0);

    // T1: plain word
    a_st = 1'b1;
    @(negedge clk);
    a_st = 1'b0;
    a_feed(16'hCCAA, -1, 0);

    // T3: back-pressure holds DONE
    for (int k = 0; k < 10; k++) begin
      a_din = k[0];
      a_dv = k[1];
      a_st = ~k[0];
      @(negedge clk);
      chk("bp_q", 32'(a_q), 32'hCCAA);
      chk("bp_qv", 32'(a_qv), 1);
      chk("bp_busy", 32'(a_busy), 0);
    end
    a_st = 1'b0;
    a_dv = 1'b0;
    a_rdy = 1'b1;
    @(negedge clk);
    a_rdy = 1'b0;
    chk("bp_idle_qv", 32'(a_qv), 0);
    chk("bp_idle_busy", 32'(a_busy), 0);
    chk("bp_idle_q", 32'(a_q), 32'hCCAA);

    // T2: stall after index 4
    a_st = 1'b1;
    @(negedge clk);
    a_st = 1'b0;
    a_feed(16'hCCAA, 4, 3);

    // T4: back-to-back from DONE
    a_rdy = 1'b1;
    a_st = 1'b1;
    @(negedge clk);
    a_rdy = 1'b0;
    a_st = 1'b0;
    chk("b2b_busy", 32'(a_busy), 1);
    chk("b2b_qv", 32'(a_qv), 0);
    chk("b2b_clr", 32'(a_q), 0);
    a_feed(16'h0F0F, -1, 0);
    a_rdy = 1'b1;
    @(negedge clk);
    a_rdy = 1'b0;
    chk("b2b_idle", 32'(a_qv), 0);

    // T6: async reset after 7 bits
    exp16 = 16'hFFFF;
    a_st = 1'b1;
    @(negedge clk);
    a_st = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("r_sel", 32'(a_sel), i);
      a_dv = 1'b1;
      a_din = exp16[i];
      @(negedge clk);
    end
    chk("r_q_part", 32'(a_q), 32'h7F);
    #2 reset = 1'b1;
    #1;
    chk("r_q", 32'(a_q), 0);
    chk("r_sel0", 32'(a_sel), 0);
    chk("r_qv", 32'(a_qv), 0);
    chk("r_busy", 32'(a_busy), 0);
    @(negedge clk);
    a_dv = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("r_idle", 32'(a_busy), 0);
    a_st = 1'b1;
    @(negedge clk);
    a_st = 1'b0;
    a_feed(16'h1234, -1, 0);
    a_rdy = 1'b1;
    @(negedge clk);
    a_rdy = 1'b0;

    // T5: N=5 wraps at 4
    w5 = 5'b10110;
    b_st = 1'b1;
    @(negedge clk);
    b_st = 1'b0;
    sb5.push_back(w5);
    for (int i = 0; i < 5; i++) begin
      chk("b_sel", 32'(b_sel), i);
      chk("b_qv_low", 32'(b_qv), 0);
      b_dv = 1'b1;
      b_din = w5[i];
      @(negedge clk);
    end
    b_dv = 1'b0;
    chk("b_sel_wrap", 32'(b_sel), 0);
    chk("b_qv", 32'(b_qv), 1);
    chk("b_sb_nonempty", 32'(sb5.size() != 0), 1);
    if (sb5.size() != 0) begin
      exp5 = sb5.pop_front();
      chk("b_word", 32'(b_q), 32'(exp5));
    end
    b_dv = 1'b1;
    @(negedge clk);
    b_dv = 1'b0;
    chk("b_hold_sel", 32'(b_sel), 0);
    chk("b_hold_q", 32'(b_q), 32'(5'b10110));
    b_rdy = 1'b1;
    @(negedge clk);
    b_rdy = 1'b0;
    chk("b_idle", 32'(b_qv), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
